// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480 @ 60 Hz VGA pixel-timing stage.
package vga_pkg;

    typedef logic [9:0] vga_coord_t;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int unsigned H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int unsigned V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

    // Half-open window test: lo <= pos < hi.
    function automatic logic in_window(vga_coord_t pos, vga_coord_t lo, vga_coord_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Tick-enabled shift register that re-aligns sync outputs with the downstream colour pipeline.
// Depth 0 is a straight pass-through.
module sync_delay_line #(
    parameter int unsigned Width    = 2,
    parameter int unsigned Depth    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    if (Depth == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_shift
        logic [Width-1:0] stage_q [Depth];
        logic [Width-1:0] stage_d [Depth];

        always_comb begin
            stage_d = stage_q;
            if (tick_i) begin
                stage_d[0] = d_i;
                for (int unsigned i = 1; i < Depth; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < Depth; i++) begin
                    stage_q[i] <= ResetVal;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q_o = stage_q[Depth-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan counters, display enable, frame marker and delayed sync pulses.
// Define VGA_PIX_DIV2_EN to advance the scan on every second clk (50 MHz system clock).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter bit          SYNC_ACTIVE = 1'b0,
    parameter int unsigned SYNC_DELAY  = 1
) (
    input  logic       clk,
    input  logic       rst,
    output vga_coord_t row,
    output vga_coord_t column,
    output logic       en,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam vga_coord_t HLast    = vga_coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam vga_coord_t VLast    = vga_coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam vga_coord_t HVis     = vga_coord_t'(H_VISIBLE);
    localparam vga_coord_t VVis     = vga_coord_t'(V_VISIBLE);
    localparam vga_coord_t HSyncLo  = vga_coord_t'(H_VISIBLE + H_FRONT);
    localparam vga_coord_t HSyncHi  = vga_coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam vga_coord_t VSyncLo  = vga_coord_t'(V_VISIBLE + V_FRONT);
    localparam vga_coord_t VSyncHi  = vga_coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic       SyncIdle = ~SYNC_ACTIVE;

    logic       tick;
    vga_coord_t h_q, h_d, v_q, v_d;
    vga_coord_t h_nxt, v_nxt;
    logic       en_q, en_d;
    logic       fs_q, fs_d;
    logic       hs_raw_q, hs_raw_d;
    logic       vs_raw_q, vs_raw_d;
    logic [1:0] sync_dly;

`ifdef VGA_PIX_DIV2_EN
    logic div_q, div_d;

    assign div_d = ~div_q;
    assign tick  = div_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Qualifiers are computed from the next position so they coincide with row/column.
    always_comb begin
        h_nxt    = (h_q == HLast) ? '0 : h_q + 1'b1;
        v_nxt    = (h_q != HLast) ? v_q : ((v_q == VLast) ? '0 : v_q + 1'b1);
        h_d      = h_q;
        v_d      = v_q;
        en_d     = en_q;
        fs_d     = fs_q;
        hs_raw_d = hs_raw_q;
        vs_raw_d = vs_raw_q;
        if (tick) begin
            h_d      = h_nxt;
            v_d      = v_nxt;
            en_d     = (h_nxt < HVis) && (v_nxt < VVis);
            fs_d     = (h_nxt == '0) && (v_nxt == '0);
            hs_raw_d = in_window(h_nxt, HSyncLo, HSyncHi) ? SYNC_ACTIVE : SyncIdle;
            vs_raw_d = in_window(v_nxt, VSyncLo, VSyncHi) ? SYNC_ACTIVE : SyncIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q      <= HLast;
            v_q      <= VLast;
            en_q     <= 1'b0;
            fs_q     <= 1'b0;
            hs_raw_q <= SyncIdle;
            vs_raw_q <= SyncIdle;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            en_q     <= en_d;
            fs_q     <= fs_d;
            hs_raw_q <= hs_raw_d;
            vs_raw_q <= vs_raw_d;
        end
    end

    sync_delay_line #(
        .Width    (2),
        .Depth    (SYNC_DELAY),
        .ResetVal ({SyncIdle, SyncIdle})
    ) u_sync_dly (
        .clk_i  (clk),
        .rst_ni (rst),
        .tick_i (tick),
        .d_i    ({hs_raw_q, vs_raw_q}),
        .q_o    (sync_dly)
    );

    assign row         = v_q;
    assign column      = h_q;
    assign en          = en_q;
    assign frame_start = fs_q;
    assign hsync       = sync_dly[1];
    assign vsync       = sync_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen; uses a short vertical frame so full frames fit the run.
module tb_vga_timing_gen;

    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 8, VF = 2, VS = 2, VB = 3;
    localparam int DLY = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int HS_LO = HV + HF, HS_HI = HV + HF + HS;
    localparam int VS_LO = VV + VF, VS_HI = VV + VF + VS;
`ifdef VGA_PIX_DIV2_EN
    localparam int CPT = 2;
`else
    localparam int CPT = 1;
`endif

    typedef struct {
        int   row;
        int   col;
        logic en;
        logic hs;
        logic vs;
        logic fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] row, column;
    logic       en, hsync, vsync, frame_start;

    int n_checks = 0;
    int n_fail = 0;

    exp_t       exp_q[$];
    logic [1:0] hist[$];

    vga_timing_gen #(
        .H_VISIBLE   (HV),
        .H_FRONT     (HF),
        .H_SYNC      (HS),
        .H_BACK      (HB),
        .V_VISIBLE   (VV),
        .V_FRONT     (VF),
        .V_SYNC      (VS),
        .V_BACK      (VB),
        .SYNC_ACTIVE (1'b0),
        .SYNC_DELAY  (DLY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .column      (column),
        .en          (en),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: linear pixel index plus a FIFO standing in for the sync delay.
    int   m_pos = FRAME - 1;
    logic m_div = 1'b0;
    logic m_en = 1'b0, m_fs = 1'b0, m_hs = 1'b1, m_vs = 1'b1;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_pos = FRAME - 1;
                m_en  = 1'b0;
                m_fs  = 1'b0;
                m_hs  = 1'b1;
                m_vs  = 1'b1;
                m_div = 1'b0;
                hist.delete();
                for (int i = 0; i < DLY; i++) hist.push_back(2'b11);
            end else begin
                logic       tk;
                logic [1:0] s;
                int         h, v;
                tk    = (CPT == 2) ? m_div : 1'b1;
                m_div = ~m_div;
                if (tk) begin
                    m_pos = (m_pos + 1) % FRAME;
                    h     = m_pos % HT;
                    v     = m_pos / HT;
                    m_en  = (h < HV) && (v < VV);
                    m_fs  = (m_pos == 0);
                    hist.push_back({!(h >= HS_LO && h < HS_HI), !(v >= VS_LO && v < VS_HI)});
                    s     = hist.pop_front();
                    m_hs  = s[1];
                    m_vs  = s[0];
                end
            end
            exp_q.push_back('{row: m_pos / HT, col: m_pos % HT, en: m_en, hs: m_hs, vs: m_vs,
                              fs: m_fs});
        end
    end

    // Scoreboard compare plus edge/width monitors, all on the falling edge.
    logic prev_hs, prev_vs, prev_en, prev_fs, hs_in, vs_in, fs_seen;
    int   prev_row, prev_col, hs_run, vs_run, fs_gap;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check_eq("sb_empty", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("sb_row", 32'(row), 32'(e.row));
                check_eq("sb_col", 32'(column), 32'(e.col));
                check_eq("sb_en", 32'(en), 32'(e.en));
                check_eq("sb_hsync", 32'(hsync), 32'(e.hs));
                check_eq("sb_vsync", 32'(vsync), 32'(e.vs));
                check_eq("sb_fs", 32'(frame_start), 32'(e.fs));
            end
            if (!rst) begin
                prev_hs = 1'b1; prev_vs = 1'b1; prev_en = 1'b0; prev_fs = 1'b0;
                hs_in = 1'b0; vs_in = 1'b0; fs_seen = 1'b0;
                prev_row = VT - 1; prev_col = HT - 1;
                hs_run = 0; vs_run = 0; fs_gap = 0;
            end else begin
                if (!hsync) begin
                    if (prev_hs) begin
                        check_eq("hs_first_col", 32'(column), 32'(HS_LO + DLY));
                        hs_in = 1'b1; hs_run = 0;
                    end
                    hs_run++;
                end else if (!prev_hs && hs_in) begin
                    check_eq("hs_width", 32'(hs_run), 32'(HS * CPT));
                end
                if (!vsync) begin
                    if (prev_vs) begin
                        check_eq("vs_first_row", 32'(row), 32'(VS_LO));
                        check_eq("vs_first_col", 32'(column), 32'(DLY));
                        vs_in = 1'b1; vs_run = 0;
                    end
                    vs_run++;
                end else if (!prev_vs && vs_in) begin
                    check_eq("vs_width", 32'(vs_run), 32'(VS * HT * CPT));
                end
                if (frame_start && !prev_fs) begin
                    if (fs_seen) check_eq("frame_period", 32'(fs_gap), 32'(FRAME * CPT));
                    fs_seen = 1'b1; fs_gap = 0;
                end
                fs_gap++;
                if (!en && prev_en) check_eq("en_fall_col", 32'(column), 32'(HV));
                if (en && !prev_en) check_eq("en_rise_col", 32'(column), 32'd0);
                if (prev_col == HT - 1 && column == 10'd0) begin
                    check_eq("row_inc", 32'(row), 32'((prev_row + 1) % VT));
                end
                prev_hs = hsync; prev_vs = vsync; prev_en = en; prev_fs = frame_start;
                prev_row = int'(row); prev_col = int'(column);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_row", 32'(row), 32'(VT - 1));
        check_eq("rst_col", 32'(column), 32'(HT - 1));
        check_eq("rst_en", 32'(en), 32'd0);
        check_eq("rst_hsync", 32'(hsync), 32'd1);
        check_eq("rst_vsync", 32'(vsync), 32'd1);
        check_eq("rst_fs", 32'(frame_start), 32'd0);
        #1 rst = 1'b1;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 8);
        check_eq("first_tick_lat", 32'(n), 32'(CPT));
        check_eq("first_row", 32'(row), 32'd0);
        check_eq("first_col", 32'(column), 32'd0);
        check_eq("first_en", 32'(en), 32'd1);

        repeat ((FRAME + 50) * CPT) @(negedge clk);

        n = 0;
        while (!(row == 10'(VS_LO) && column == 10'd700) && n < (FRAME + 10) * CPT) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_found", 32'(row == 10'(VS_LO) && column == 10'd700), 32'd1);
        check_eq("mid_vsync_low", 32'(vsync), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_hsync", 32'(hsync), 32'd1);
        check_eq("mid_rst_vsync", 32'(vsync), 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 8);
        check_eq("restart_lat", 32'(n), 32'(CPT));
        check_eq("restart_row", 32'(row), 32'd0);
        check_eq("restart_col", 32'(column), 32'd0);

        repeat (2 * HT * CPT) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
